// File: rtl/frame_packer.sv
// Buffers a 1-8 word payload from a valid/ready stream, then emits one gap-free frame:
// header, channel word, payload, CRC-16/CCITT, trailer, big-endian on a registered 16-bit bus.
module frame_packer #(
    parameter logic [31:0] HEADER    = 32'hE0E0E0E0,
    parameter logic [31:0] TRAILER   = 32'h0E0E0E0E,
    parameter int unsigned HDR_HOLD  = 1,
    parameter logic [15:0] IDLE_WORD = 16'h0000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  channel,
    input  logic [3:0]  len,
    input  logic        abort,
    input  logic [15:0] pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic [15:0] data_out,
    output logic        busy,
    output logic        frame_done,
    output logic        req_err
);

    localparam int          DATA_W   = 16;
    localparam int          BUF_D    = 8;
    localparam logic [1:0]  HOLD_L   = 2'(HDR_HOLD);
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_HDR_H,
        S_HDR_L,
        S_CHAN,
        S_DATA,
        S_CRC,
        S_TRL_H,
        S_TRL_L
    } state_t;

    // One payload word folded into the CRC, MSB first, 16 bits per call.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [1:0]          r_hold;
    logic [3:0]          r_len;
    logic [7:0]          r_chan;
    logic [15:0]         r_crc;
    logic [DATA_W-1:0]   r_buf [BUF_D];
    logic [15:0]         r_data_out;
    logic                r_frame_done;
    logic                r_req_err;

    state_t              w_state_nxt;
    logic [3:0]          w_cnt_nxt;
    logic [1:0]          w_hold_nxt;
    logic [3:0]          w_len_nxt;
    logic [7:0]          w_chan_nxt;
    logic [15:0]         w_crc_nxt;
    logic                w_buf_we;
    logic [15:0]         w_word_nxt;
    logic                w_done_nxt;
    logic                w_req_err_nxt;
    logic                w_req_ok;
    logic                w_cnt_last;

    assign w_req_ok   = (len >= 4'd1) && (len <= 4'd8) &&
                        (channel != 8'h00) && ((channel & (channel - 8'd1)) == 8'h00);
    assign w_cnt_last = (r_cnt == (r_len - 4'd1));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hold_nxt    = r_hold;
        w_len_nxt     = r_len;
        w_chan_nxt    = r_chan;
        w_crc_nxt     = r_crc;
        w_buf_we      = 1'b0;
        w_done_nxt    = 1'b0;
        w_req_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_req_ok) begin
                        w_state_nxt = S_LOAD;
                        w_chan_nxt  = channel;
                        w_len_nxt   = len;
                        w_crc_nxt   = 16'h0000;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_req_err_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // abort wins over a transfer in the same cycle
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (pay_valid) begin
                    w_buf_we  = 1'b1;
                    w_crc_nxt = crc16_word(r_crc, pay_data);
                    if (w_cnt_last) begin
                        w_state_nxt = S_HDR_H;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            S_HDR_H: begin
                w_state_nxt = S_HDR_L;
                w_hold_nxt  = 2'd0;
            end
            S_HDR_L: begin
                if (r_hold == HOLD_L) begin
                    w_state_nxt = S_CHAN;
                end else begin
                    w_hold_nxt = r_hold + 2'd1;
                end
            end
            S_CHAN: begin
                w_state_nxt = S_DATA;
                w_cnt_nxt   = 4'd0;
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_CRC;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_CRC:   w_state_nxt = S_TRL_H;
            S_TRL_H: w_state_nxt = S_TRL_L;
            S_TRL_L: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The output register is loaded with the word of the state being entered.
    always_comb begin
        w_word_nxt = IDLE_WORD;
        case (w_state_nxt)
            S_HDR_H: w_word_nxt = HEADER[31:16];
            S_HDR_L: w_word_nxt = HEADER[15:0];
            S_CHAN:  w_word_nxt = {8'h00, w_chan_nxt};
            S_DATA:  w_word_nxt = r_buf[w_cnt_nxt[2:0]];
            S_CRC:   w_word_nxt = r_crc;
            S_TRL_H: w_word_nxt = TRAILER[31:16];
            S_TRL_L: w_word_nxt = TRAILER[15:0];
            default: w_word_nxt = IDLE_WORD;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_hold       <= 2'd0;
            r_len        <= 4'd0;
            r_chan       <= 8'h00;
            r_crc        <= 16'h0000;
            r_data_out   <= IDLE_WORD;
            r_frame_done <= 1'b0;
            r_req_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hold       <= w_hold_nxt;
            r_len        <= w_len_nxt;
            r_chan       <= w_chan_nxt;
            r_crc        <= w_crc_nxt;
            r_data_out   <= w_word_nxt;
            r_frame_done <= w_done_nxt;
            r_req_err    <= w_req_err_nxt;
        end
    end

    // Payload storage carries data only, so it has no reset.
    always_ff @(posedge clk_in) begin
        if (w_buf_we) begin
            r_buf[r_cnt[2:0]] <= pay_data;
        end
    end

    assign pay_ready  = (r_state == S_LOAD);
    assign busy       = (r_state != S_IDLE);
    assign data_out   = r_data_out;
    assign frame_done = r_frame_done;
    assign req_err    = r_req_err;

endmodule

// File: tb/tb_frame_packer.sv
// Directed, table-driven bench for frame_packer: frame layout, CRC, illegal requests,
// abort, asynchronous reset mid-frame and back-to-back frames.
module tb_frame_packer;

    localparam int          HOLD = 1;
    localparam logic [31:0] HDR  = 32'hE0E0E0E0;
    localparam logic [31:0] TRL  = 32'h0E0E0E0E;
    localparam logic [15:0] IDLE = 16'h0000;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  channel;
    logic [3:0]  len;
    logic        abort;
    logic [15:0] pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic [15:0] data_out;
    logic        busy;
    logic        frame_done;
    logic        req_err;

    int n_vec = 0;
    int n_mis = 0;

    frame_packer #(
        .HEADER   (HDR),
        .TRAILER  (TRL),
        .HDR_HOLD (HOLD),
        .IDLE_WORD(IDLE)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (start),
        .channel   (channel),
        .len       (len),
        .abort     (abort),
        .pay_data  (pay_data),
        .pay_valid (pay_valid),
        .pay_ready (pay_ready),
        .data_out  (data_out),
        .busy      (busy),
        .frame_done(frame_done),
        .req_err   (req_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [7:0]       ch;
        logic [3:0]       len;
        logic [7:0][15:0] pay;
        int               gap_at;
        int               gaps;
        bit               legal;
        bit               use_model;
        logic [15:0]      crc;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input logic [7:0] ch, input logic [3:0] ln, input bit legal,
                                input bit use_model, input logic [15:0] crc);
        vec_t v;
        v           = '0;
        v.ch        = ch;
        v.len       = ln;
        v.legal     = legal;
        v.use_model = use_model;
        v.crc       = crc;
        v.gap_at    = -1;
        v.gaps      = 0;
        return v;
    endfunction

    // Reference CRC by polynomial long division of ((crc ^ word) * x^16) mod 0x11021.
    function automatic logic [15:0] m_crc(input vec_t v);
        logic [15:0] c;
        logic [31:0] r;
        c = 16'h0000;
        for (int i = 0; i < int'(v.len); i++) begin
            r = {c ^ v.pay[i], 16'h0000};
            for (int b = 31; b >= 16; b--) begin
                if (r[b]) r = r ^ (32'h0001_1021 << (b - 16));
            end
            c = r[15:0];
        end
        return c;
    endfunction

    function automatic logic [15:0] exp_word(input vec_t v, input int k, input logic [15:0] c);
        int n;
        n = int'(v.len);
        if (k == 0)            return HDR[31:16];
        if (k <= 1 + HOLD)     return HDR[15:0];
        if (k == 2 + HOLD)     return {8'h00, v.ch};
        if (k < 3 + HOLD + n)  return v.pay[k - 3 - HOLD];
        if (k == 3 + HOLD + n) return c;
        if (k == 4 + HOLD + n) return TRL[31:16];
        return TRL[15:0];
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input string tag, input vec_t v, input bit pre, input bit chain,
                             input vec_t nxt);
        int          nw;
        logic [15:0] crc_exp;
        if (!pre) begin
            start   = 1'b1;
            channel = v.ch;
            len     = v.len;
        end
        tick();
        start = 1'b0;
        if (!v.legal) begin
            chk({tag, " req_err"}, 16'(req_err), 16'd1);
            chk({tag, " busy"}, 16'(busy), 16'd0);
            chk({tag, " data_out"}, data_out, IDLE);
            chk({tag, " pay_ready"}, 16'(pay_ready), 16'd0);
            tick();
            chk({tag, " req_err pulse"}, 16'(req_err), 16'd0);
            return;
        end
        chk({tag, " load busy"}, 16'(busy), 16'd1);
        chk({tag, " load pay_ready"}, 16'(pay_ready), 16'd1);
        chk({tag, " load req_err"}, 16'(req_err), 16'd0);
        chk({tag, " load data_out"}, data_out, IDLE);
        for (int i = 0; i < int'(v.len); i++) begin
            if (i == v.gap_at) begin
                for (int g = 0; g < v.gaps; g++) begin
                    pay_valid = 1'b0;
                    tick();
                    chk({tag, " bubble pay_ready"}, 16'(pay_ready), 16'd1);
                    chk({tag, " bubble data_out"}, data_out, IDLE);
                end
            end
            pay_valid = 1'b1;
            pay_data  = v.pay[i];
            tick();
        end
        pay_valid = 1'b0;
        pay_data  = 16'hDEAD;
        crc_exp   = v.use_model ? m_crc(v) : v.crc;
        nw        = 6 + HOLD + int'(v.len);
        chk({tag, " tx busy"}, 16'(busy), 16'd1);
        chk({tag, " tx pay_ready"}, 16'(pay_ready), 16'd0);
        for (int k = 0; k < nw; k++) begin
            chk($sformatf("%s word%0d", tag, k), data_out, exp_word(v, k, crc_exp));
            chk($sformatf("%s done%0d", tag, k), 16'(frame_done), 16'd0);
            tick();
        end
        chk({tag, " frame_done"}, 16'(frame_done), 16'd1);
        chk({tag, " end data_out"}, data_out, IDLE);
        chk({tag, " end busy"}, 16'(busy), 16'd0);
        if (chain) begin
            start   = 1'b1;
            channel = nxt.ch;
            len     = nxt.len;
        end else begin
            tick();
            chk({tag, " frame_done pulse"}, 16'(frame_done), 16'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t w;
        int   bad;

        rst_n = 1'b0; start = 1'b0; channel = 8'h00; len = 4'd0;
        abort = 1'b0; pay_data = 16'h0000; pay_valid = 1'b0;

        tbl[0] = mk(8'h01, 4'd1, 1'b1, 1'b0, 16'h1021);
        tbl[0].pay[0] = 16'h0001;
        tbl[1] = mk(8'h02, 4'd8, 1'b1, 1'b0, 16'h1021);
        tbl[1].pay[7] = 16'h0001;
        tbl[1].gap_at = 3;
        tbl[1].gaps   = 3;
        tbl[2] = mk(8'h01, 4'd0,  1'b0, 1'b0, 16'h0000);
        tbl[3] = mk(8'h01, 4'd9,  1'b0, 1'b0, 16'h0000);
        tbl[4] = mk(8'h03, 4'd1,  1'b0, 1'b0, 16'h0000);
        tbl[5] = mk(8'h00, 4'd1,  1'b0, 1'b0, 16'h0000);
        tbl[6] = mk(8'h01, 4'd15, 1'b0, 1'b0, 16'h0000);
        tbl[7] = mk(8'h80, 4'd3, 1'b1, 1'b1, 16'h0000);
        tbl[7].pay[0] = 16'hA5A5;
        tbl[7].pay[1] = 16'h5A5A;
        tbl[7].pay[2] = 16'hFFFF;
        tbl[8] = mk(8'h10, 4'd2, 1'b1, 1'b1, 16'h0000);
        tbl[8].pay[0] = 16'h0001;
        tbl[8].pay[1] = 16'h0000;
        tbl[9] = mk(8'h04, 4'd5, 1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 5; i++) tbl[9].pay[i] = 16'(16'h1357 * (i + 1));
        tbl[9].gap_at = 0;
        tbl[9].gaps   = 2;

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst data_out", data_out, IDLE);
        chk("rst busy", 16'(busy), 16'd0);
        chk("rst pay_ready", 16'(pay_ready), 16'd0);
        chk("rst frame_done", 16'(frame_done), 16'd0);
        chk("rst req_err", 16'(req_err), 16'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i], 1'b0, 1'b0, tbl[i]);
        end

        // Abort after two of four words, then a len=1 frame carrying 0x0002.
        start = 1'b1; channel = 8'h04; len = 4'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pay_valid = 1'b1;
            pay_data  = 16'h00A0 + 16'(i);
            tick();
        end
        abort     = 1'b1;
        pay_data  = 16'hBEEF;
        tick();
        abort     = 1'b0;
        pay_valid = 1'b0;
        chk("abort busy", 16'(busy), 16'd0);
        chk("abort pay_ready", 16'(pay_ready), 16'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (data_out !== IDLE || frame_done !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        chk("abort quiet cycles", 16'(bad), 16'd0);
        v = mk(8'h01, 4'd1, 1'b1, 1'b0, 16'h2042);
        v.pay[0] = 16'h0002;
        run_frame("post_abort", v, 1'b0, 1'b0, v);

        // Asynchronous reset in the middle of the payload of an 8-word frame.
        v = mk(8'h08, 4'd8, 1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 8; i++) v.pay[i] = 16'(16'h1111 * i);
        start = 1'b1; channel = v.ch; len = v.len;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pay_valid = 1'b1;
            pay_data  = v.pay[i];
            tick();
        end
        pay_valid = 1'b0;
        repeat (3 + HOLD) tick();
        chk("arst pre data0", data_out, v.pay[0]);
        tick();
        chk("arst pre data1", data_out, v.pay[1]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst data_out", data_out, IDLE);
        chk("arst busy", 16'(busy), 16'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (data_out !== IDLE || frame_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("arst no resume", 16'(bad), 16'd0);
        run_frame("post_arst", v, 1'b0, 1'b0, v);

        // Back-to-back: second start issued in the frame_done cycle.
        v = mk(8'h20, 4'd1, 1'b1, 1'b1, 16'h0000);
        v.pay[0] = 16'h00FF;
        w = mk(8'h40, 4'd2, 1'b1, 1'b1, 16'h0000);
        w.pay[0] = 16'h1234;
        w.pay[1] = 16'h8000;
        run_frame("b2b_a", v, 1'b0, 1'b1, w);
        run_frame("b2b_b", w, 1'b1, 1'b0, w);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
